// File: rtl/rb_arb_pkg.sv
// Shared types for the ring-buffer write-port arbiter.
package rb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rb_if.sv
// Valid/ready/data channel into the ring_buffer write side.
interface rb_if #(
    parameter type data_t = logic
);
    logic  valid;
    logic  ready;
    data_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first requester strictly after `last`, wrapping at N.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Offsets 1..N so that `last` itself is checked last, giving it lowest priority.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rb_rr_arbiter.sv
// Round-robin arbiter granting one producer at a time a burst on the ring_buffer write port.
module rb_rr_arbiter
    import rb_arb_pkg::*;
#(
    parameter type data_t    = logic,
    parameter int  N         = 4,
    parameter int  MAX_BURST = 8,
    parameter int  IW        = $clog2(N),
    parameter int  BW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_valid,
    input  logic [N-1:0]  in_last,
    input  data_t         in_data [N],
    output logic [N-1:0]  in_ready,
    rb_if.master          o_bus,
    output logic [IW-1:0] grant_id,
    output logic          busy
);

    arb_state_e    state;
    logic [IW-1:0] last_grant;
    logic [BW-1:0] burst_cnt;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          cur_valid;
    logic          cur_last;
    logic          beat;
    logic          burst_full;
    logic          release_now;

    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req     (in_valid),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign cur_valid  = in_valid[grant_id];
    assign cur_last   = in_last[grant_id];
    assign beat       = (state == GRANT) && cur_valid && o_bus.ready;
    assign burst_full = (burst_cnt == BW'(MAX_BURST - 1));

    // A GRANT cycle with no pending beat releases immediately; otherwise only an accepted beat can end the burst.
    assign release_now = (state == GRANT) &&
                         (!cur_valid || (beat && (cur_last || burst_full)));

    // Ready depends only on registered state and o_bus.ready, never on in_valid.
    always_comb begin
        o_bus.valid = 1'b0;
        o_bus.data  = in_data[grant_id];
        in_ready    = '0;
        if (state == GRANT) begin
            o_bus.valid        = cur_valid;
            in_ready[grant_id] = o_bus.ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(N - 1);
            grant_id   <= '0;
            burst_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= GRANT;
                        busy       <= 1'b1;
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        burst_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                    if (release_now) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb_rr_arbiter.sv
// Directed bench for rb_rr_arbiter: N=4, MAX_BURST=8, byte payload.
module tb_rb_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] din [4];
    logic       rdy;
    logic [3:0] in_ready;
    logic [1:0] grant_id;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int beats;

    rb_if #(.data_t(logic [7:0])) bus ();
    assign bus.ready = rdy;

    rb_rr_arbiter #(
        .data_t    (logic [7:0]),
        .N         (N),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vld),
        .in_last  (lst),
        .in_data  (din),
        .in_ready (in_ready),
        .o_bus    (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = '0;
        lst = '0;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset values, with a request already pending
        rst = 1'b1;
        vld = 4'b0100;
        lst = '0;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        din[2] = 8'h0A;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_ready", in_ready, 0);

        // Single producer 2: A, B, C with last on C
        rst = 1'b0;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", in_ready, 0);
        tick(); #1;
        chk("t1_gid", grant_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_valid_a", bus.valid, 1);
        chk("t1_data_a", bus.data, 8'h0A);
        chk("t1_ready", in_ready, 4'b0100);
        tick(); din[2] = 8'h0B; #1;
        chk("t1_data_b", bus.data, 8'h0B);
        chk("t1_valid_b", bus.valid, 1);
        tick(); din[2] = 8'h0C; lst = 4'b0100; #1;
        chk("t1_data_c", bus.data, 8'h0C);
        chk("t1_ready_c", in_ready, 4'b0100);
        tick(); vld = '0; lst = '0; #1;
        chk("t1_rel_busy", busy, 0);
        chk("t1_rel_valid", bus.valid, 0);
        tick(); #1;
        chk("t1_stay_idle", busy, 0);

        // All requesting, no last: 0,1,2,3,0 with 8 beats each and one idle cycle between
        do_reset();
        vld = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 8'h10 + 8'(i);
        #1;
        chk("t2_c0_busy", busy, 0);
        for (int b = 0; b < 5; b++) begin
            beats = 0;
            for (int k = 0; k < MB; k++) begin
                tick(); #1;
                chk("t2_busy", busy, 1);
                chk("t2_gid", grant_id, b % 4);
                chk("t2_ready", in_ready, 1 << (b % 4));
                chk("t2_data", bus.data, 8'h10 + 8'(b % 4));
                if (bus.valid && in_ready[b % 4]) beats++;
            end
            tick(); #1;
            chk("t2_gap_busy", busy, 0);
            chk("t2_gap_valid", bus.valid, 0);
            chk("t2_beats", beats, MB);
        end

        // Back-pressure: 5 stalled cycles after 2 beats, burst still totals 8 beats
        do_reset();
        vld = 4'b0001;
        din[0] = 8'h50;
        #1;
        chk("t3_c0_busy", busy, 0);
        for (int k = 0; k < 2; k++) begin
            tick(); din[0] = 8'h50 + 8'(k); #1;
            chk("t3_pre_data", bus.data, 8'h50 + 8'(k));
            chk("t3_pre_ready", in_ready, 4'b0001);
        end
        for (int s = 0; s < 5; s++) begin
            tick(); din[0] = 8'h52; rdy = 1'b0; #1;
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_stall_valid", bus.valid, 1);
            chk("t3_stall_data", bus.data, 8'h52);
            chk("t3_stall_busy", busy, 1);
            chk("t3_stall_gid", grant_id, 0);
        end
        for (int k = 2; k < MB; k++) begin
            tick(); rdy = 1'b1; din[0] = 8'h50 + 8'(k); #1;
            chk("t3_post_busy", busy, 1);
            chk("t3_post_data", bus.data, 8'h50 + 8'(k));
            chk("t3_post_ready", in_ready, 4'b0001);
        end
        tick(); #1;
        chk("t3_rel_busy", busy, 0);
        tick(); #1;
        chk("t3_regrant_busy", busy, 1);
        chk("t3_regrant_gid", grant_id, 0);
        vld = '0; #1;
        chk("t3_drop_valid", bus.valid, 0);
        tick(); #1;
        chk("t3_drop_rel", busy, 0);

        // Valid dropout on producer 1 while producer 3 requests
        do_reset();
        vld = 4'b0010;
        din[1] = 8'h61;
        #1;
        tick(); #1;
        chk("t4_gid1", grant_id, 1);
        chk("t4_busy1", busy, 1);
        tick(); #1;
        chk("t4_beat2_busy", busy, 1);
        tick(); vld = 4'b1000; din[3] = 8'h73; #1;
        chk("t4_drop_busy", busy, 1);
        chk("t4_drop_gid", grant_id, 1);
        chk("t4_drop_valid", bus.valid, 0);
        tick(); #1;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_ready", in_ready, 0);
        tick(); lst = 4'b1000; #1;
        chk("t4_gid3", grant_id, 3);
        chk("t4_busy3", busy, 1);
        chk("t4_data3", bus.data, 8'h73);
        chk("t4_ready3", in_ready, 4'b1000);
        tick(); vld = '0; lst = '0; #1;
        chk("t4_last_rel", busy, 0);

        // Reset mid-burst after beat 3 of producer 1
        do_reset();
        vld = 4'b0010;
        din[1] = 8'h81;
        #1;
        tick(); #1;
        chk("t5_gid1", grant_id, 1);
        tick(); #1;
        tick(); #1;
        chk("t5_beat3_busy", busy, 1);
        tick(); rst = 1'b1; #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", bus.valid, 0);
        chk("t5_rst_ready", in_ready, 0);
        chk("t5_rst_gid", grant_id, 0);
        vld = 4'hF; #1;
        chk("t5_rst_hold_valid", bus.valid, 0);
        tick(); rst = 1'b0; #1;
        chk("t5_post_idle", busy, 0);
        tick(); #1;
        chk("t5_first_gid", grant_id, 0);
        chk("t5_first_busy", busy, 1);

        // last on the 8th beat: one release; request raised mid-burst waits for IDLE
        do_reset();
        vld = 4'b0100;
        #1;
        for (int k = 0; k < MB; k++) begin
            tick();
            din[2] = 8'h90 + 8'(k);
            if (k >= 4) vld[0] = 1'b1;
            if (k == MB - 1) lst = 4'b0100;
            #1;
            chk("t6_busy", busy, 1);
            chk("t6_gid", grant_id, 2);
            chk("t6_data", bus.data, 8'h90 + 8'(k));
        end
        tick(); vld[2] = 1'b0; lst = '0; #1;
        chk("t6_rel_busy", busy, 0);
        tick(); #1;
        chk("t6_next_busy", busy, 1);
        chk("t6_next_gid", grant_id, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rb_rr_arbiter.md
# rb_rr_arbiter

- Round-robin arbiter that shares one `ring_buffer` write port between `N` producers.
- Each cycle in IDLE it picks the next requesting producer after the last one served, then connects that producer to `o_bus` for one burst.
- Grants are registered, so there is one idle cycle between bursts.
- Sits directly in front of `ring_buffer.i_bus`. Producers see a plain valid/ready handshake.

## Interface

Parameters:
- `data_t`, default `logic`: payload type, identical to the downstream ring_buffer's `data_t`.
- `N`, default `4`: number of producers, ≥ 2.
- `MAX_BURST`, default `8`: maximum beats per grant, ≥ 1.
- `IW`, default `$clog2(N)`: grant index width.
- `BW`, default `$clog2(MAX_BURST+1)`: burst counter width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  `[N]`  per-producer valid.
- `in_last`  in  `[N]`  per-producer end-of-packet marker; meaningful only when the matching `in_valid` is 1.
- `in_data`  in  `data_t [N]`  per-producer payload.
- `in_ready`  out  `[N]`  per-producer ready.
- `o_bus`  `rb_if.master`  `data_t`  output to the ring_buffer write side (valid/ready/data).
- `grant_id`  out  `IW`  index of the current or most recent grant.
- `busy`  out  1  high while in GRANT.

## Operation

- **States:** IDLE, GRANT (2-state FSM).
- **IDLE:**
  - `o_bus.valid` = 0 and all `in_ready` = 0.
  - If any `in_valid` is set, select the first requester at or after `(last_grant+1) mod N`, scanning upward and wrapping.
  - Register the winner into `grant_id` and `last_grant`, clear `burst_cnt`, go to GRANT.
- **GRANT**, with `g` = `grant_id`:
  - `o_bus.valid` = `in_valid[g]`, `o_bus.data` = `in_data[g]`.
  - `in_ready[g]` = `o_bus.ready`; every other `in_ready` = 0.
  - A beat is accepted when `in_valid[g]` & `o_bus.ready`; each accepted beat increments `burst_cnt`.
- **Release** (go to IDLE next cycle) when any of these holds:
  - an accepted beat has `in_last[g]` = 1;
  - an accepted beat brings `burst_cnt+1` to `MAX_BURST`;
  - `in_valid[g]` = 0 in a GRANT cycle (no beat pending, so release is safe).
- **Output stall:** `o_bus.ready` low (ring_buffer full) with `in_valid[g]` high holds GRANT indefinitely; no timeout.
- **Simultaneous events:** `in_last` and the `MAX_BURST` limit on the same beat give a single release. New requests arriving during GRANT are evaluated only in the next IDLE.
- **Wrap-around:** the priority pointer wraps from `N-1` to 0. A lone requester is re-granted every other cycle.
- **Handshake contract:** producers must hold valid/data/last stable until accepted. The arbiter never deasserts `o_bus.valid` while `in_valid[g]` is high in GRANT.
- **Width rule:** `burst_cnt` is `BW` bits and never exceeds `MAX_BURST`.
- **Reset values:**
  - state = IDLE, `last_grant` = `N-1` (producer 0 has first priority), `grant_id` = 0, `burst_cnt` = 0.
  - `busy` = 0, `o_bus.valid` = 0, `in_ready` = all 0.
- **Reset mid-burst:** the arbiter returns to IDLE immediately. No beat is accepted while `rst` is high; any partial packet is the producer's responsibility.

## Timing

- **Grant latency:**
  - request seen in IDLE at cycle t → GRANT and `busy` = 1 at t+1;
  - first beat can be accepted at t+1;
  - `o_bus` pass-through is combinational from the selected input.
- **Release latency:** release condition at cycle t → IDLE at t+1 → next grant visible at t+2.
- **Throughput:** at most `MAX_BURST` beats per `MAX_BURST+1` cycles across requesters.
- **Combinational paths:** `o_bus.ready` → `in_ready[g]` is combinational. No combinational path from `in_valid` to `in_ready`.

## Structure

- **Package `rb_arb_pkg`:** state enum `arb_state_e` {IDLE, GRANT}.
- **Sub-module `rr_picker`:** combinational rotate-priority encoder.
  - Inputs: `req[N]`, `last[IW]`.
  - Outputs: `gnt_idx[IW]`, `any`.
  - Reusable by later schedulers.
- **Top level:** FSM, burst counter and output mux.

## Test plan

- **Single producer:** reset, then producer 2 sends 3 beats (0xA, 0xB, 0xC, last on 0xC) with `o_bus.ready` = 1 → `grant_id` = 2 one cycle after valid; `o_bus` carries A, B, C on consecutive cycles; IDLE the cycle after C.
- **All requesting:** all 4 producers continuously valid, `MAX_BURST` = 8, no `last` → grants in order 0, 1, 2, 3, 0; exactly 8 beats each; one idle cycle between bursts.
- **Back-pressure:** `o_bus.ready` held low 5 cycles mid-burst → `in_ready[g]` = 0, data stable, grant held, `burst_cnt` unchanged; resumes without loss.
- **Valid dropout:** granted producer drops valid after 2 beats while producer 3 requests → release, then producer 3 is granted 2 cycles after the dropout.
- **Reset mid-burst:** assert `rst` after beat 3 of producer 1 → outputs at reset values in the same cycle; after release the first grant goes to producer 0 when all request.
